// File: rtl/twocmp_pkg.sv
// Shared types for the bit-serial two's complement unit.
package twocmp_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_NEG  = 2'd1,
        OP_ABS  = 2'd2,
        OP_INV  = 2'd3
    } twocmp_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } twocmp_state_e;

endpackage

// File: rtl/twocmp_bitcell.sv
// One bit of the serial two's complement rule: copy up to and including
// the first one, invert every bit after it.
module twocmp_bitcell (
    input  logic b,
    input  logic seen_in,
    input  logic neg,
    input  logic inv,
    output logic out_bit,
    output logic seen_out
);

    always_comb begin
        out_bit  = b;
        seen_out = seen_in | b;
        if (inv) begin
            out_bit = ~b;
        end else if (neg && seen_in) begin
            out_bit = ~b;
        end
    end

endmodule

// File: rtl/twocmp_seq.sv
// Bit-serial two's complement unit: captures an operand on start, processes
// it LSB first one bit per clock, and publishes out/ovf with a done pulse.
module twocmp_seq
    import twocmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    twocmp_state_e    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             neg_q, neg_d;
    logic             inv_q, inv_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;

    twocmp_op_e op_e;
    logic       bit_out;
    logic       seen_out;

    assign op_e = twocmp_op_e'(op);

    twocmp_bitcell u_cell (
        .b        (src_q[0]),
        .seen_in  (seen_q),
        .neg      (neg_q),
        .inv      (inv_q),
        .out_bit  (bit_out),
        .seen_out (seen_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        neg_d   = neg_q;
        inv_d   = inv_q;
        src_d   = src_q;
        res_d   = res_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    src_d   = a;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                    neg_d   = (op_e == OP_NEG) || ((op_e == OP_ABS) && a[WIDTH-1]);
                    inv_d   = (op_e == OP_INV);
                end
            end
            RUN: begin
                // Operand shifts out at bit 0 while results shift in at the MSB.
                src_d  = src_q >> 1;
                res_d  = {bit_out, res_q[WIDTH-1:1]};
                seen_d = seen_out;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    out_d   = {bit_out, res_q[WIDTH-1:1]};
                    ovf_d   = neg_q & ~seen_q & src_q[0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            neg_q   <= 1'b0;
            inv_q   <= 1'b0;
            src_q   <= '0;
            res_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            neg_q   <= neg_d;
            inv_q   <= inv_d;
            src_q   <= src_d;
            res_q   <= res_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign out  = out_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_twocmp_seq.sv
// Directed bench for twocmp_seq at WIDTH=8 and WIDTH=4 with a result scoreboard.
module tb_twocmp_seq;

    logic       clk;
    logic       rst;
    logic       start8, start4;
    logic [1:0] op8, op4;
    logic [7:0] a8;
    logic [3:0] a4;
    logic       busy8, done8, ovf8;
    logic       busy4, done4, ovf4;
    logic [7:0] out8;
    logic [3:0] out4;

    int checks = 0;
    int errors = 0;
    int ph8 = 0;
    int ph4 = 0;
    logic [32:0] q8[$];
    logic [32:0] q4[$];

    twocmp_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8),
        .busy(busy8), .done(done8), .out(out8), .ovf(ovf8)
    );

    twocmp_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4),
        .busy(busy4), .done(done4), .out(out4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Arithmetic reference: returns {ovf, result} for a w-bit operand.
    function automatic logic [32:0] model(input int w, input logic [31:0] av, input logic [1:0] opv);
        logic [31:0] mask;
        logic [31:0] r;
        logic        neg;
        logic        ov;
        mask = (32'h1 << w) - 32'h1;
        neg  = (opv == 2'd1) || ((opv == 2'd2) && av[w-1]);
        if (opv == 2'd3)
            r = ~av & mask;
        else if (neg)
            r = (~av + 32'h1) & mask;
        else
            r = av & mask;
        ov = neg && ((av & mask) == (32'h1 << (w - 1)));
        return {ov, r};
    endfunction

    // One clock: track acceptance/done timing, then check both units.
    task automatic tick();
        logic        s8, s4;
        logic [32:0] e8, e4, got;
        s8 = start8;
        s4 = start4;
        e8 = model(8, {24'b0, a8}, op8);
        e4 = model(4, {28'b0, a4}, op4);
        @(posedge clk);
        if (ph8 == 0) begin
            if (s8) begin ph8 = 1; q8.push_back(e8); end
        end else begin
            ph8 = (ph8 == 9) ? 0 : ph8 + 1;
        end
        if (ph4 == 0) begin
            if (s4) begin ph4 = 1; q4.push_back(e4); end
        end else begin
            ph4 = (ph4 == 5) ? 0 : ph4 + 1;
        end
        #1;
        chk("busy8", 32'(busy8), 32'(ph8 != 0));
        chk("done8", 32'(done8), 32'(ph8 == 9));
        chk("busy4", 32'(busy4), 32'(ph4 != 0));
        chk("done4", 32'(done4), 32'(ph4 == 5));
        if (ph8 == 9 && q8.size() > 0) begin
            got = q8.pop_front();
            chk("out8", 32'(out8), got[31:0]);
            chk("ovf8", 32'(ovf8), 32'(got[32]));
        end
        if (ph4 == 5 && q4.size() > 0) begin
            got = q4.pop_front();
            chk("out4", 32'(out4), got[31:0]);
            chk("ovf4", 32'(ovf4), 32'(got[32]));
        end
    endtask

    task automatic run8(input logic [7:0] av, input logic [1:0] opv);
        a8 = av; op8 = opv; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = ~av;
        op8 = 2'($urandom_range(3));
        repeat (9) tick();
    endtask

    task automatic run4(input logic [3:0] av, input logic [1:0] opv);
        a4 = av; op4 = opv; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        a4 = ~av;
        repeat (5) tick();
    endtask

    initial begin
        logic prev_done;
        logic prev_busy;
        int   accepts;
        rst = 1'b1;
        start8 = 1'b0; start4 = 1'b0;
        op8 = 2'd0; op4 = 2'd0;
        a8 = '0; a4 = '0;
        #3;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_out8",  32'(out8),  32'd0);
        chk("rst_ovf8",  32'(ovf8),  32'd0);
        chk("rst_out4",  32'(out4),  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        run8(8'h05, 2'd1);
        chk("neg05_out", 32'(out8), 32'h0000_00FB);
        run8(8'h80, 2'd1);
        chk("neg80_ovf", 32'(ovf8), 32'd1);
        run8(8'h80, 2'd2);
        chk("abs80_out", 32'(out8), 32'h0000_0080);
        run8(8'hF6, 2'd2);
        run8(8'h0A, 2'd2);
        run8(8'h3C, 2'd3);
        run8(8'h00, 2'd1);
        run8(8'h5A, 2'd0);

        // start held high with a changing every cycle
        prev_done = 1'b0;
        prev_busy = busy8;
        accepts = 0;
        start8 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            a8  = 8'($urandom_range(255));
            op8 = 2'($urandom_range(3));
            tick();
            chk("done_b2b", 32'(prev_done & done8), 32'd0);
            if (busy8 && !prev_busy) accepts++;
            prev_done = done8;
            prev_busy = busy8;
        end
        start8 = 1'b0;
        chk("accepts", 32'(accepts), 32'd3);
        repeat (10) tick();

        // reset asserted while bit 3 is processing
        run8(8'h3C, 2'd3);
        a8 = 8'h77; op8 = 2'd1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_busy", 32'(busy8), 32'd0);
        chk("mid_done", 32'(done8), 32'd0);
        chk("mid_out",  32'(out8),  32'd0);
        chk("mid_ovf",  32'(ovf8),  32'd0);
        #1 rst = 1'b0;
        ph8 = 0; ph4 = 0;
        q8.delete(); q4.delete();
        repeat (10) tick();
        run8(8'h01, 2'd1);
        chk("neg01_out", 32'(out8), 32'h0000_00FF);

        run4(4'h1, 2'd1);
        chk("w4_neg1", 32'(out4), 32'h0000_000F);
        run4(4'h8, 2'd1);
        chk("w4_ovf", 32'(ovf4), 32'd1);
        run4(4'h6, 2'd2);
        run4(4'hA, 2'd2);

        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/twocmp_seq.md
# twocmp_seq

Parametrised, bit-serial two's complement unit, the next generation of the combinational 4-bit `twocmp`. It captures a WIDTH-bit operand on `start` and applies one of four operations. It processes one bit per clock, LSB first, using the copy-through-first-one / invert-rest rule. The result is presented with a one-cycle `done` pulse and an overflow flag. It sits in the arithmetic datapath wherever area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  operation select: OP_PASS=0, OP_NEG=1, OP_ABS=2, OP_INV=3
- a  in  WIDTH  operand, two's complement
- busy  out  1  high while state is RUN or DONE
- done  out  1  one-cycle pulse; `out` and `ovf` valid from this cycle on
- out  out  WIDTH  result register, held until the next completion
- ovf  out  1  result not representable; held with `out`

## Operation
- FSM states:
  - IDLE: waits for `start`. `start`=1 at a clock edge → RUN; `a` and `op` are latched into internal registers, bit counter=0, seen_one=0.
  - RUN: processes one bit per edge, counter 0..WIDTH-1. After the edge that processes bit WIDTH-1 → DONE.
  - DONE: `done`=1 for exactly one cycle, then → IDLE.
- Effective negate flag, fixed at capture:
  - OP_NEG: 1
  - OP_ABS: equals latched a[WIDTH-1]
  - OP_PASS, OP_INV: 0
- Per-bit rule for input bit b:
  - negate: out_bit = seen_one ? ~b : b; then seen_one |= b
  - OP_INV: out_bit = ~b
  - otherwise: out_bit = b
- Result bits shift into an internal register. `out` is loaded from it on the edge entering DONE. `out` never shows partial results.
- ovf=1 iff negate is in effect and the operand is the most-negative value (MSB=1, all lower bits 0). Detected at bit WIDTH-1 as seen_one=0 and b=1. Result in that case = 1 followed by WIDTH-1 zeros (wraps). `ovf` updates together with `out`.
- Changes on `a`/`op` after capture have no effect.
- `start` in RUN or DONE is ignored; there is no queueing. `start` held high is re-accepted in the first IDLE cycle.

## Timing
- Reset values: state IDLE, busy=0, done=0, out=0, ovf=0, counter=0, seen_one=0.
- `rst` asserted at any time, including mid-RUN, forces reset values immediately. The in-flight operation is discarded and no `done` is issued.
- Latency: `start` sampled at edge E. `done`=1 in the cycle after edge E+WIDTH, and `out` is valid in that same cycle.
- Throughput: one operation per WIDTH+2 cycles with `start` held high.
- `busy` rises after edge E and falls after edge E+WIDTH+1.
- Counter width is $clog2(WIDTH); its wrap from WIDTH-1 is never observed.

## Structure
- Package `twocmp_pkg`:
  - op encoding as enum `twocmp_op_e`: OP_PASS, OP_NEG, OP_ABS, OP_INV
  - FSM enum `twocmp_state_e`: IDLE, RUN, DONE
- Sub-module `twocmp_bitcell`: combinational single-bit cell.
  - Inputs: b, seen_in, neg, inv.
  - Outputs: out_bit, seen_out.
  - The top-level module holds the FSM, counter, shift registers and result/overflow registers.

## Test plan
- WIDTH=8, a=8'h05, OP_NEG: done 9 cycles after the start edge; out=8'hFB, ovf=0.
- WIDTH=8, a=8'h80, OP_NEG: out=8'h80, ovf=1. Repeated with OP_ABS: same result.
- WIDTH=8, a=8'hF6, OP_ABS: out=8'h0A, ovf=0. Then a=8'h0A, OP_ABS: out=8'h0A. Then a=8'h3C, OP_INV: out=8'hC3. Then a=8'h00, OP_NEG: out=8'h00, ovf=0.
- Handshake: `start` held high for 30 cycles with `a` changed every cycle.
  - Operations are accepted exactly every 10 cycles.
  - Each result matches the `a` value sampled at its acceptance edge.
  - `done` is never high two cycles in a row.
- Reset mid-RUN: `rst` pulsed while bit 3 is processing. All outputs read 0 immediately and no `done` follows. A new start with a=8'h01, OP_NEG then gives out=8'hFF.
- WIDTH=4 instance: a=4'h1, OP_NEG → out=4'hF, done 5 cycles after the start edge; a=4'h8, OP_NEG → out=4'h8, ovf=1.
